id_ex_pipeline_reg: RTL and testbench
=====================================

// Module: id_ex_pipeline_reg
// PURPOSE
//  ID/EX pipeline register with integrated load-use hazard detection and WB write-through.
//  Captures decoded operands, register specifiers and control from ID each cycle.
//  Drives ID_EX_Rs/ID_EX_Rt into the EX-stage forwarding unit.
//  Stalls PC and IF/ID and inserts one bubble on a load-use hazard; zeroes control on flush.
// PARAMETERS
//  DATA_W   32  operand/immediate width
//  REG_AW   5   register specifier width
//  CNT_W    16  bubble performance counter width
// PORTS
//  clk              in   1       rising-edge clock
//  rst_n            in   1       asynchronous active-low reset
//  id_rd1, id_rd2   in   DATA_W  register file read data (Rs, Rt)
//  id_imm           in   DATA_W  sign-extended immediate
//  id_rs,id_rt,id_rd in  REG_AW  register specifiers from IF/ID
//  id_uses_rs/rt    in   1       instruction actually reads Rs / Rt
//  id_ctrl          in   9       {RegDst,ALUSrc,ALUOp[2:0],MemRead,MemWrite,RegWrite,MemToReg}
//  flush            in   1       branch/jump resolved taken; kill instruction in ID
//  MEM_WB_RegWrite  in   1       WB-stage write enable
//  MEM_WB_Rd        in   REG_AW  WB-stage destination
//  MEM_WB_Data      in   DATA_W  WB-stage write data
//  ID_EX_A, ID_EX_B out  DATA_W  registered operands
//  ID_EX_Imm        out  DATA_W  registered immediate
//  ID_EX_Rs/Rt/Rd   out  REG_AW  registered specifiers (to forwarding unit)
//  ID_EX_Ctrl       out  9       registered control, same packing as id_ctrl
//  pc_write         out  1       0 = hold PC this cycle
//  if_id_write      out  1       0 = hold IF/ID this cycle
//  bubble_count     out  CNT_W   saturating count of inserted bubbles/flushes
// BEHAVIOUR
//  - Reset (async, rst_n=0): all registered outputs 0, bubble_count 0 (control 0 = NOP);
//    pc_write=if_id_write=1 immediately after.
//  - Latency: 1 cycle; ID inputs at edge N appear on ID_EX_* after edge N.
//  - Load-use hazard (combinational): ID_EX_Ctrl.MemRead && ID_EX_Rt!=0 &&
//    ((id_uses_rs && id_rs==ID_EX_Rt) || (id_uses_rt && id_rt==ID_EX_Rt)).
//  - Priority per edge: flush > hazard > normal.
//    flush:  ID_EX_Ctrl<=0; specifiers<=0; pc_write=if_id_write=1; bubble_count++.
//    hazard: ID_EX_Ctrl<=0, ID_EX_Rs/Rt/Rd<=0 (bubble); pc_write=if_id_write=0; bubble_count++.
//    normal: capture all ID fields; pc_write=if_id_write=1.
//  - Hazard produces exactly one bubble: next cycle ID_EX MemRead=0, so the stall clears.
//  - WB write-through: if MEM_WB_RegWrite && MEM_WB_Rd!=0 && MEM_WB_Rd==id_rs,
//    capture MEM_WB_Data into ID_EX_A instead of id_rd1; same for id_rt -> ID_EX_B.
//  - Register 0 never hazards and never bypasses.
//  - bubble_count saturates at all-ones; never wraps.
//  - Data fields (A,B,Imm) may hold stale values in a bubble; only Ctrl and specifiers are zeroed.
//  - rst_n asserted mid-stall: outputs clear immediately, stall released.
// STRUCTURE
//  - Shared include pipeline_defs.vh: ctrl bit positions (CTRL_REGDST..CTRL_MEMTOREG),
//    CTRL_W=9, ALUOp encodings, NOP control constant.
//  - Sub-module hazard_detect_unit: combinational load-use compare -> stall.
//  - Top: instantiates hazard_detect_unit; holds registers, bypass muxes, counter.
// TESTING
//  1 Reset: rst_n=0 mid-cycle -> all ID_EX_* and bubble_count 0 at once; pc_write=1.
//  2 lw $2 then add $3,$2,$4 -> 1 cycle pc_write=if_id_write=0; ID_EX_Ctrl=0; add enters next cycle; count=1.
//  3 lw $0 then add $3,$0,$4 -> no stall; lw $2 then addi (uses_rt=0, id_rt=2) -> no stall.
//  4 flush and hazard same cycle -> Ctrl=0, pc_write=1, count +1 (not +2).
//  5 MEM_WB writes $5=0xDEADBEEF while id_rs=5, id_rd1=0 -> ID_EX_A=0xDEADBEEF; Rd=0 -> id_rd1 kept.
//  6 Force count to 0xFFFE, 3 bubbles -> bubble_count holds 0xFFFF.

Source files
------------

// File: rtl/id_ex_pipeline_reg_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_pipeline_reg_pkg
//   Shared pipeline definitions for the ID/EX stage: control-word width and
//   bit positions, ALUOp encodings and the NOP control word.
//   Control packing (MSB..LSB):
//     {RegDst, ALUSrc, ALUOp[2:0], MemRead, MemWrite, RegWrite, MemToReg}
// ---------------------------------------------------------------------------
package id_ex_pipeline_reg_pkg;

  localparam int CTRL_W = 9;

  localparam int CTRL_REGDST   = 8;
  localparam int CTRL_ALUSRC   = 7;
  localparam int CTRL_ALUOP_HI = 6;
  localparam int CTRL_ALUOP_LO = 4;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_MEMTOREG = 0;

  localparam logic [2:0] ALUOP_ADD    = 3'b000;
  localparam logic [2:0] ALUOP_SUB    = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE  = 3'b010;
  localparam logic [2:0] ALUOP_AND    = 3'b011;
  localparam logic [2:0] ALUOP_OR     = 3'b100;
  localparam logic [2:0] ALUOP_SLT    = 3'b101;

  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_pipeline_reg_hazard_detect_unit.sv
// ---------------------------------------------------------------------------
// hazard_detect_unit
//   Combinational load-use detection. A stall is raised when the instruction
//   in EX is a load whose destination (Rt) is a register actually read by the
//   instruction in ID. Register 0 never hazards.
// Ports
//   ex_mem_read  in   1       MemRead of the instruction in EX
//   ex_rt        in   REG_AW  load destination in EX
//   id_rs/id_rt  in   REG_AW  source specifiers in ID
//   id_uses_rs/rt in  1       ID instruction really reads Rs / Rt
//   stall        out  1       load-use hazard present
// ---------------------------------------------------------------------------
module hazard_detect_unit #(
  parameter int REG_AW = 5
) (
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  output logic              stall
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match = id_uses_rs && (id_rs == ex_rt);
    rt_match = id_uses_rt && (id_rt == ex_rt);
    stall    = ex_mem_read && (ex_rt != '0) && (rs_match || rt_match);
  end

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipeline_reg
//   ID/EX pipeline register with load-use stall, flush bubbling and WB
//   write-through bypass of the register-file read data.
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_rd1/id_rd2/id_imm       ID operands and sign-extended immediate
//   id_rs/id_rt/id_rd          ID register specifiers
//   id_uses_rs/id_uses_rt      ID instruction reads Rs / Rt
//   id_ctrl                    ID control word (see package for packing)
//   flush                      kill the instruction currently in ID
//   MEM_WB_RegWrite/Rd/Data    write-back port, bypassed into A/B
//   ID_EX_A/B/Imm              registered operands
//   ID_EX_Rs/Rt/Rd             registered specifiers (forwarding unit)
//   ID_EX_Ctrl                 registered control
//   pc_write/if_id_write       0 = hold PC / IF/ID this cycle
//   bubble_count               saturating count of inserted bubbles
// ---------------------------------------------------------------------------
module id_ex_pipeline_reg
  import id_ex_pipeline_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              MEM_WB_RegWrite,
  input  logic [REG_AW-1:0] MEM_WB_Rd,
  input  logic [DATA_W-1:0] MEM_WB_Data,
  output logic [DATA_W-1:0] ID_EX_A,
  output logic [DATA_W-1:0] ID_EX_B,
  output logic [DATA_W-1:0] ID_EX_Imm,
  output logic [REG_AW-1:0] ID_EX_Rs,
  output logic [REG_AW-1:0] ID_EX_Rt,
  output logic [REG_AW-1:0] ID_EX_Rd,
  output logic [CTRL_W-1:0] ID_EX_Ctrl,
  output logic              pc_write,
  output logic              if_id_write,
  output logic [CNT_W-1:0]  bubble_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == '1) sat_inc = v;
    else         sat_inc = v + 1'b1;
  endfunction

  // Register 0 is hardwired, so a write to it must never be bypassed.
  function automatic logic [DATA_W-1:0] wb_bypass(
    input logic [DATA_W-1:0] rf_data,
    input logic [REG_AW-1:0] src,
    input logic              wb_we,
    input logic [REG_AW-1:0] wb_rd,
    input logic [DATA_W-1:0] wb_data
  );
    if (wb_we && (wb_rd != '0) && (wb_rd == src)) wb_bypass = wb_data;
    else                                            wb_bypass = rf_data;
  endfunction

  logic              stall;
  logic              bubble_p0;
  logic [DATA_W-1:0] a_p0;
  logic [DATA_W-1:0] b_p0;

  hazard_detect_unit #(
    .REG_AW (REG_AW)
  ) u_hazard_detect_unit (
    .ex_mem_read (ID_EX_Ctrl[CTRL_MEMREAD]),
    .ex_rt       (ID_EX_Rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .stall       (stall)
  );

  // ID stage: flush overrides the stall, so the front end keeps moving to
  // fetch the branch target while the killed instruction becomes a bubble.
  always_comb begin
    bubble_p0   = flush || stall;
    pc_write    = flush || !stall;
    if_id_write = flush || !stall;
    a_p0        = wb_bypass(id_rd1, id_rs, MEM_WB_RegWrite, MEM_WB_Rd, MEM_WB_Data);
    b_p0        = wb_bypass(id_rd2, id_rt, MEM_WB_RegWrite, MEM_WB_Rd, MEM_WB_Data);
  end

  // ID -> EX boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ID_EX_A      <= '0;
      ID_EX_B      <= '0;
      ID_EX_Imm    <= '0;
      ID_EX_Rs     <= '0;
      ID_EX_Rt     <= '0;
      ID_EX_Rd     <= '0;
      ID_EX_Ctrl   <= CTRL_NOP;
      bubble_count <= '0;
    end else begin
      // Data fields are don't-care inside a bubble, so they load every cycle.
      ID_EX_A   <= a_p0;
      ID_EX_B   <= b_p0;
      ID_EX_Imm <= id_imm;
      if (bubble_p0) begin
        ID_EX_Ctrl   <= CTRL_NOP;
        ID_EX_Rs     <= '0;
        ID_EX_Rt     <= '0;
        ID_EX_Rd     <= '0;
        bubble_count <= sat_inc(bubble_count);
      end else begin
        ID_EX_Ctrl <= id_ctrl;
        ID_EX_Rs   <= id_rs;
        ID_EX_Rt   <= id_rt;
        ID_EX_Rd   <= id_rd;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
module tb_id_ex_pipeline_reg;
  import id_ex_pipeline_reg_pkg::*;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 16;

  // Hand-packed control words {RegDst,ALUSrc,ALUOp,MemRead,MemWrite,RegWrite,MemToReg}
  localparam logic [CTRL_W-1:0] C_LW   = 9'b0_1_000_1_0_1_1; // 0x08B
  localparam logic [CTRL_W-1:0] C_ADD  = 9'b1_0_010_0_0_1_0; // 0x122
  localparam logic [CTRL_W-1:0] C_ADDI = 9'b0_1_000_0_0_1_0; // 0x082

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] id_rd1, id_rd2, id_imm;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic              id_uses_rs, id_uses_rt;
  logic [CTRL_W-1:0] id_ctrl;
  logic              flush;
  logic              MEM_WB_RegWrite;
  logic [REG_AW-1:0] MEM_WB_Rd;
  logic [DATA_W-1:0] MEM_WB_Data;
  logic [DATA_W-1:0] ID_EX_A, ID_EX_B, ID_EX_Imm;
  logic [REG_AW-1:0] ID_EX_Rs, ID_EX_Rt, ID_EX_Rd;
  logic [CTRL_W-1:0] ID_EX_Ctrl;
  logic              pc_write, if_id_write;
  logic [CNT_W-1:0]  bubble_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_pipeline_reg #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .CNT_W  (CNT_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rd1          (id_rd1),
    .id_rd2          (id_rd2),
    .id_imm          (id_imm),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rd           (id_rd),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_ctrl         (id_ctrl),
    .flush           (flush),
    .MEM_WB_RegWrite (MEM_WB_RegWrite),
    .MEM_WB_Rd       (MEM_WB_Rd),
    .MEM_WB_Data     (MEM_WB_Data),
    .ID_EX_A         (ID_EX_A),
    .ID_EX_B         (ID_EX_B),
    .ID_EX_Imm       (ID_EX_Imm),
    .ID_EX_Rs        (ID_EX_Rs),
    .ID_EX_Rt        (ID_EX_Rt),
    .ID_EX_Rd        (ID_EX_Rd),
    .ID_EX_Ctrl      (ID_EX_Ctrl),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .bubble_count    (bubble_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [CTRL_W-1:0] c, input logic [REG_AW-1:0] rs,
                           input logic [REG_AW-1:0] rt, input logic [REG_AW-1:0] rd,
                           input logic urs, input logic urt);
    id_ctrl    = c;
    id_rs      = rs;
    id_rt      = rt;
    id_rd      = rd;
    id_uses_rs = urs;
    id_uses_rt = urt;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    id_rd1 = '0; id_rd2 = '0; id_imm = '0;
    set_instr(C_ADD, 5'd7, 5'd8, 5'd9, 1'b1, 1'b1);
    id_rd1 = 32'h1111_0000; id_rd2 = 32'h2222_0000; id_imm = 32'h0000_0042;
    flush = 1'b0;
    MEM_WB_RegWrite = 1'b0; MEM_WB_Rd = '0; MEM_WB_Data = '0;

    // Load something non-zero, then reset mid-cycle: clear must be immediate.
    step();
    step();
    check("pre_rst_ctrl", 64'(ID_EX_Ctrl), 64'(C_ADD));
    async_reset();
    check("rst_ctrl",  64'(ID_EX_Ctrl),   64'h0);
    check("rst_a",     64'(ID_EX_A),      64'h0);
    check("rst_imm",   64'(ID_EX_Imm),    64'h0);
    check("rst_rd",    64'(ID_EX_Rd),     64'h0);
    check("rst_cnt",   64'(bubble_count), 64'h0);
    check("rst_pcw",   64'(pc_write),     64'h1);
    check("rst_ifidw", 64'(if_id_write),  64'h1);
    step();
    rst_n = 1'b1;

    // lw $2 then add $3,$2,$4 -> one stall cycle then add proceeds
    set_instr(C_LW, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
    step();
    check("lw_ctrl", 64'(ID_EX_Ctrl), 64'h08B);
    check("lw_rt",   64'(ID_EX_Rt),   64'd2);
    set_instr(C_ADD, 5'd2, 5'd4, 5'd3, 1'b1, 1'b1);
    #1;
    check("lu_pcw",   64'(pc_write),    64'h0);
    check("lu_ifidw", 64'(if_id_write), 64'h0);
    step();
    check("lu_bub_ctrl", 64'(ID_EX_Ctrl),   64'h0);
    check("lu_bub_rt",   64'(ID_EX_Rt),     64'h0);
    check("lu_cnt",      64'(bubble_count), 64'd1);
    check("lu_release",  64'(pc_write),     64'h1);
    step();
    check("lu_add_ctrl", 64'(ID_EX_Ctrl),   64'h122);
    check("lu_add_rd",   64'(ID_EX_Rd),     64'd3);
    check("lu_cnt2",     64'(bubble_count), 64'd1);

    // lw $0 then add $3,$0,$4 -> no stall
    set_instr(C_LW, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0);
    step();
    set_instr(C_ADD, 5'd0, 5'd4, 5'd3, 1'b1, 1'b1);
    #1;
    check("r0_pcw", 64'(pc_write), 64'h1);
    step();
    check("r0_ctrl", 64'(ID_EX_Ctrl), 64'h122);

    // lw $2 then addi with id_rt=2 but uses_rt=0 -> no stall
    set_instr(C_LW, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
    step();
    set_instr(C_ADDI, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
    #1;
    check("addi_pcw", 64'(pc_write), 64'h1);
    step();
    check("addi_ctrl", 64'(ID_EX_Ctrl),   64'h082);
    check("addi_cnt",  64'(bubble_count), 64'd1);

    // flush and hazard in the same cycle -> one bubble, front end not held
    set_instr(C_LW, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
    step();
    set_instr(C_ADD, 5'd2, 5'd4, 5'd3, 1'b1, 1'b1);
    flush = 1'b1;
    #1;
    check("fl_pcw",   64'(pc_write),    64'h1);
    check("fl_ifidw", 64'(if_id_write), 64'h1);
    step();
    flush = 1'b0;
    check("fl_ctrl", 64'(ID_EX_Ctrl),   64'h0);
    check("fl_rd",   64'(ID_EX_Rd),     64'h0);
    check("fl_cnt",  64'(bubble_count), 64'd2);

    // WB write-through into A; Rt path unaffected
    set_instr(C_ADD, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1);
    id_rd1 = 32'h0; id_rd2 = 32'h0000_1234; id_imm = 32'hFFFF_FFF0;
    MEM_WB_RegWrite = 1'b1; MEM_WB_Rd = 5'd5; MEM_WB_Data = 32'hDEAD_BEEF;
    step();
    check("wb_a",   64'(ID_EX_A),   64'hDEAD_BEEF);
    check("wb_b",   64'(ID_EX_B),   64'h1234);
    check("wb_imm", 64'(ID_EX_Imm), 64'hFFFF_FFF0);
    // bypass into B
    set_instr(C_ADD, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1);
    id_rd1 = 32'h0000_00AA;
    step();
    check("wb_b2", 64'(ID_EX_B), 64'hDEAD_BEEF);
    check("wb_a2", 64'(ID_EX_A), 64'hAA);
    // write to $0 never bypasses
    set_instr(C_ADD, 5'd0, 5'd3, 5'd7, 1'b1, 1'b1);
    id_rd1 = 32'h0000_0055;
    MEM_WB_Rd = 5'd0;
    step();
    check("wb_r0", 64'(ID_EX_A), 64'h55);
    // RegWrite low never bypasses
    set_instr(C_ADD, 5'd5, 5'd3, 5'd7, 1'b1, 1'b1);
    id_rd1 = 32'h0000_0066;
    MEM_WB_Rd = 5'd5; MEM_WB_RegWrite = 1'b0;
    step();
    check("wb_nowe", 64'(ID_EX_A), 64'h66);

    // reset while stalled releases the stall at once
    set_instr(C_LW, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
    step();
    set_instr(C_ADD, 5'd2, 5'd4, 5'd3, 1'b1, 1'b1);
    #1;
    check("ms_stall", 64'(pc_write), 64'h0);
    async_reset();
    check("ms_pcw",  64'(pc_write),     64'h1);
    check("ms_ctrl", 64'(ID_EX_Ctrl),   64'h0);
    check("ms_cnt",  64'(bubble_count), 64'h0);
    step();
    rst_n = 1'b1;

    // saturation: 0xFFFE flushes, then 3 more
    flush = 1'b1;
    repeat (16'hFFFE) step();
    check("sat_fffe", 64'(bubble_count), 64'hFFFE);
    repeat (3) step();
    check("sat_ffff", 64'(bubble_count), 64'hFFFF);
    flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
